// File: rtl/freq_meter_ctrl.sv
// Frequency-meter sequencer: selects the generator test mode (manual or auto-scan),
// waits out a settle interval, counts sigin rising edges over a fixed gate, latches the result.
module freq_meter_ctrl #(
  parameter int GATE_CYCLES   = 100000000,
  parameter int SETTLE_CYCLES = 4000000,
  parameter int DWELL_GATES   = 3,
  parameter int CNT_W         = 24
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic             auto,
  input  logic [1:0]       sw_mode,
  input  logic             sigin,
  output logic [1:0]       testmode,
  output logic [CNT_W-1:0] freq,
  output logic             freq_valid,
  output logic             overflow,
  output logic             gate
);

  localparam int GATE_W   = $clog2(GATE_CYCLES);
  localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int TMR_W    = (GATE_W > SETTLE_W) ? GATE_W : SETTLE_W;
  localparam int DWELL_W  = (DWELL_GATES > 1) ? $clog2(DWELL_GATES) : 1;

  localparam logic [TMR_W-1:0]   GATE_LAST   = TMR_W'(GATE_CYCLES - 1);
  localparam logic [TMR_W-1:0]   SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST  = DWELL_W'(DWELL_GATES - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX     = '1;

  typedef enum logic [1:0] {ST_SETTLE, ST_GATE, ST_LATCH} state_t;

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sat_q, sat_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [1:0]         scan_q, scan_d;
  logic               auto_q, auto_d;
  logic [1:0]         testmode_q, testmode_d;
  logic [CNT_W-1:0]   freq_q, freq_d;
  logic               overflow_q, overflow_d;
  logic               valid_q, valid_d;
  logic [2:0]         sync_q, sync_d;

  logic       edge_det;
  logic       advance;
  logic       mode_change;
  logic [1:0] target;

  // sync_q[1:0] is the two-flop synchroniser, sync_q[2] the previous synchronised value
  assign edge_det = sync_q[1] & ~sync_q[2];

  always_comb begin
    sync_d     = {sync_q[1:0], sigin};
    auto_d     = auto;
    scan_d     = scan_q;
    dwell_d    = dwell_q;
    state_d    = state_q;
    timer_d    = timer_q;
    cnt_d      = cnt_q;
    sat_d      = sat_q;
    freq_d     = freq_q;
    overflow_d = overflow_q;
    valid_d    = 1'b0;

    advance = (state_q == ST_LATCH) && (dwell_q == DWELL_LAST);

    // Entering auto restarts the scan at 00; the scan only steps when a latch ends its dwell
    if (!auto) begin
      target = sw_mode;
    end else if (!auto_q) begin
      target = 2'b00;
    end else if (advance) begin
      target = scan_q + 2'd1;
    end else begin
      target = scan_q;
    end
    testmode_d  = target;
    mode_change = (target != testmode_q);

    if (auto) begin
      scan_d = target;
      if (!auto_q) begin
        dwell_d = '0;
      end else if (state_q == ST_LATCH) begin
        dwell_d = advance ? '0 : dwell_q + 1'b1;
      end
    end

    case (state_q)
      ST_SETTLE: begin
        if (mode_change) begin
          timer_d = '0;
        end else if (timer_q == SETTLE_LAST) begin
          state_d = ST_GATE;
          timer_d = '0;
          cnt_d   = '0;
          sat_d   = 1'b0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_GATE: begin
        if (mode_change) begin
          state_d = ST_SETTLE;
          timer_d = '0;
          cnt_d   = '0;
          sat_d   = 1'b0;
        end else begin
          if (edge_det) begin
            if (cnt_q == CNT_MAX) begin
              sat_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          if (timer_q == GATE_LAST) begin
            state_d = ST_LATCH;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end
      ST_LATCH: begin
        freq_d     = cnt_q;
        overflow_d = sat_q;
        valid_d    = 1'b1;
        cnt_d      = '0;
        sat_d      = 1'b0;
        timer_d    = '0;
        state_d    = mode_change ? ST_SETTLE : ST_GATE;
      end
      default: begin
        state_d = ST_SETTLE;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_SETTLE;
      timer_q    <= '0;
      cnt_q      <= '0;
      sat_q      <= 1'b0;
      dwell_q    <= '0;
      scan_q     <= 2'b00;
      auto_q     <= 1'b0;
      testmode_q <= 2'b00;
      freq_q     <= '0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
      sync_q     <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      cnt_q      <= cnt_d;
      sat_q      <= sat_d;
      dwell_q    <= dwell_d;
      scan_q     <= scan_d;
      auto_q     <= auto_d;
      testmode_q <= testmode_d;
      freq_q     <= freq_d;
      overflow_q <= overflow_d;
      valid_q    <= valid_d;
      sync_q     <= sync_d;
    end
  end

  assign testmode   = testmode_q;
  assign freq       = freq_q;
  assign freq_valid = valid_q;
  assign overflow   = overflow_q;
  assign gate       = (state_q == ST_GATE);

endmodule

// File: tb/tb_freq_meter_ctrl.sv
// Directed testbench for freq_meter_ctrl: a vector table for steady-state measurements
// plus hand-written sequences for abort, auto-scan, auto release and async reset.
module tb_freq_meter_ctrl;

  localparam int GATE   = 1000;
  localparam int SETTLE = 50;
  localparam int DWELL  = 2;
  localparam int CW     = 8;

  logic          sysclk = 1'b0;
  logic          reset;
  logic          auto;
  logic [1:0]    sw_mode;
  logic          sigin;
  logic [1:0]    testmode;
  logic [CW-1:0] freq;
  logic          freq_valid;
  logic          overflow;
  logic          gate;

  int         testsRun;
  int         testsFailed;
  int         cyc;
  int         sigPeriod = 40;
  int         lowRun;
  int         lastLowRun;
  logic [1:0] gateMode;

  typedef struct {
    int            period;
    logic [1:0]    mode;
    int            discard;
    bit            chkFreq;
    logic [CW-1:0] expFreq;
    logic          expOvf;
  } vec_t;

  vec_t vecs[8];

  freq_meter_ctrl #(
    .GATE_CYCLES  (GATE),
    .SETTLE_CYCLES(SETTLE),
    .DWELL_GATES  (DWELL),
    .CNT_W        (CW)
  ) dut (
    .sysclk    (sysclk),
    .reset     (reset),
    .auto      (auto),
    .sw_mode   (sw_mode),
    .sigin     (sigin),
    .testmode  (testmode),
    .freq      (freq),
    .freq_valid(freq_valid),
    .overflow  (overflow),
    .gate      (gate)
  );

  always #5 sysclk = ~sysclk;

  // Square wave of sigPeriod sysclk cycles (0 holds sigin low), changed away from the clock edge
  initial begin : sigGen
    int ph;
    ph    = 0;
    sigin = 1'b0;
    forever begin
      @(posedge sysclk);
      #2;
      if (sigPeriod <= 0) begin
        sigin = 1'b0;
        ph    = 0;
      end else begin
        ph++;
        if (ph >= sigPeriod) ph = 0;
        sigin = (ph < sigPeriod / 2);
      end
    end
  end

  task automatic tick();
    @(posedge sysclk);
    #1;
    cyc++;
    if (gate) begin
      if (lowRun != 0) lastLowRun = lowRun;
      lowRun   = 0;
      gateMode = testmode;
    end else begin
      lowRun++;
    end
  endtask

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic checkRange(input string name, input int act, input int lo, input int hi);
    testsRun++;
    if (act < lo || act > hi) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic waitValid(input string name, input int budget, output bit ok);
    int n;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < budget) begin
      tick();
      n++;
      if (freq_valid) ok = 1'b1;
    end
    if (!ok) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL %s: got no freq_valid, expected one within %0d cycles", name, budget);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    sigPeriod = v.period;
    sw_mode   = v.mode;
  endtask

  task automatic checkOutput(input int idx, input vec_t v);
    if (v.chkFreq) checkValue($sformatf("vec%0d freq", idx), freq, v.expFreq);
    checkValue($sformatf("vec%0d overflow", idx), overflow, v.expOvf);
    checkValue($sformatf("vec%0d testmode", idx), testmode, v.mode);
  endtask

  initial begin : mainSeq
    bit            ok;
    int            prevCyc;
    int            nLow;
    bit            seenValid;
    logic [CW-1:0] freqBefore;
    logic [1:0]    seq[9];

    testsRun    = 0;
    testsFailed = 0;
    cyc         = 0;
    lowRun      = 0;
    lastLowRun  = 0;
    gateMode    = 2'b00;
    reset       = 1'b1;
    auto        = 1'b0;
    sw_mode     = 2'b01;

    // period, mode, valids to discard, check freq, expected freq, expected overflow
    vecs[0] = '{0,  2'b01, 1, 1'b1, 8'd0,   1'b0};
    vecs[1] = '{0,  2'b10, 0, 1'b1, 8'd0,   1'b0};
    vecs[2] = '{2,  2'b10, 1, 1'b1, 8'd255, 1'b1};
    vecs[3] = '{40, 2'b10, 0, 1'b0, 8'd0,   1'b0};
    vecs[4] = '{40, 2'b10, 0, 1'b1, 8'd25,  1'b0};
    vecs[5] = '{20, 2'b11, 0, 1'b1, 8'd50,  1'b0};
    vecs[6] = '{8,  2'b00, 0, 1'b1, 8'd125, 1'b0};
    vecs[7] = '{4,  2'b00, 1, 1'b1, 8'd250, 1'b0};
    seq = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};

    repeat (5) @(posedge sysclk);
    #1;
    checkValue("reset freq", freq, 0);
    checkValue("reset freq_valid", freq_valid, 0);
    checkValue("reset overflow", overflow, 0);
    checkValue("reset gate", gate, 0);

    @(negedge sysclk);
    reset = 1'b0;
    cyc   = 0;

    // First measurement: ~SETTLE + GATE + latch after release, then back-to-back every GATE+1
    waitValid("first valid", 1200, ok);
    if (ok) begin
      checkRange("first valid time", cyc, 1048, 1056);
      checkValue("first freq", freq, 25);
      checkValue("first overflow", overflow, 0);
      checkValue("first testmode", testmode, 2'b01);
    end
    prevCyc = cyc;
    waitValid("second valid", 1200, ok);
    if (ok) begin
      checkValue("second valid spacing", cyc - prevCyc, GATE + 1);
      checkValue("second freq", freq, 25);
    end

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i]);
      for (int d = 0; d < vecs[i].discard; d++) waitValid($sformatf("vec%0d discard", i), 2200, ok);
      waitValid($sformatf("vec%0d valid", i), 2200, ok);
      if (ok) checkOutput(i, vecs[i]);
    end

    // Mid-gate manual change: gate drops, settle restarts, no latch, freq holds
    repeat (500) tick();
    checkValue("abort gate open before change", gate, 1);
    freqBefore = freq;
    sw_mode    = 2'b11;
    sigPeriod  = 40;
    tick();
    checkValue("abort gate drops", gate, 0);
    checkValue("abort testmode follows switch", testmode, 2'b11);
    nLow      = 1;
    seenValid = 1'b0;
    while (!gate && nLow < 200) begin
      tick();
      if (freq_valid) seenValid = 1'b1;
      if (!gate) nLow++;
    end
    checkValue("abort settle length", nLow, SETTLE);
    checkValue("abort no valid", seenValid, 0);
    checkValue("abort freq held", freq, freqBefore);
    waitValid("post-abort valid", 1200, ok);
    if (ok) begin
      checkValue("post-abort freq", freq, 25);
      checkValue("post-abort testmode", testmode, 2'b11);
    end

    // Auto scan: two gates per mode; a mode step costs latch + settle low cycles, same mode one
    auto = 1'b1;
    for (int i = 0; i < 9; i++) begin
      waitValid($sformatf("auto valid %0d", i), 2400, ok);
      if (ok) begin
        checkValue($sformatf("auto mode %0d", i), gateMode, seq[i]);
        checkValue($sformatf("auto freq %0d", i), freq, 25);
      end
      if (i < 8) begin
        nLow = 0;
        while (!gate && nLow < 200) begin
          tick();
          nLow++;
        end
        checkValue($sformatf("auto gap %0d", i), lastLowRun, (seq[i + 1] != seq[i]) ? SETTLE + 1 : 1);
      end
    end

    // Leaving auto with the switch already on the current mode must not disturb the gate
    prevCyc = cyc;
    sw_mode = 2'b00;
    repeat (300) tick();
    auto = 1'b0;
    waitValid("auto release valid", 1200, ok);
    if (ok) begin
      checkValue("auto release spacing", cyc - prevCyc, GATE + 1);
      checkValue("auto release freq", freq, 25);
      checkValue("auto release testmode", testmode, 2'b00);
    end

    // Asynchronous reset between clock edges clears the outputs without waiting for sysclk
    repeat (400) tick();
    checkValue("pre-reset gate open", gate, 1);
    #3;
    reset = 1'b1;
    #1;
    checkValue("async reset gate", gate, 0);
    checkValue("async reset freq", freq, 0);
    checkValue("async reset freq_valid", freq_valid, 0);
    checkValue("async reset overflow", overflow, 0);
    @(negedge sysclk);
    reset = 1'b0;
    repeat (5) tick();
    checkValue("post-reset still settling", gate, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
